// File: rtl/pong_game_engine_if.sv
// Pong engine bus: frame/key strobes and paddle positions in,
// ball position, visibility, scores and game-flow flags out.
// Ports (master drives inputs of the engine, slave is the engine):
//   frame_tick, key_press, paddle1_ypos, paddle2_ypos  -> engine
//   square_xpos, square_ypos, sq_shown, score_p1, score_p2,
//   game_startup, game_over                            <- engine
interface pong_game_engine_if;
    logic       frame_tick;
    logic       key_press;
    logic [9:0] paddle1_ypos;
    logic [9:0] paddle2_ypos;
    logic [9:0] square_xpos;
    logic [9:0] square_ypos;
    logic       sq_shown;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       game_startup;
    logic       game_over;

    modport master (
        output frame_tick, key_press, paddle1_ypos, paddle2_ypos,
        input  square_xpos, square_ypos, sq_shown,
        input  score_p1, score_p2, game_startup, game_over
    );

    modport slave (
        input  frame_tick, key_press, paddle1_ypos, paddle2_ypos,
        output square_xpos, square_ypos, sq_shown,
        output score_p1, score_p2, game_startup, game_over
    );
endinterface

// File: rtl/pong_game_engine.sv
// Per-frame pong game-state engine: ball motion, wall/paddle bounces,
// scoring, serve hold and startup/play/game-over flow.
// Ports: clk_0 (pixel clock), rst (async, active-high),
//   bus (pong_game_engine_if.slave): strobes/paddles in, ball/score/flags out.
// Optional: define PONG_SPEEDUP_EN to raise x speed every 4th paddle hit.
module pong_game_engine #(
    parameter int H_VIDEO       = 640,
    parameter int V_VIDEO       = 480,
    parameter int SQUARE_WIDTH  = 16,
    parameter int PADDLE_WIDTH  = 12,
    parameter int PADDLE_HEIGHT = 96,
    parameter int PADDLE1_X     = 20,
    parameter int PADDLE2_X     = 608,
    parameter int BALL_SPEED    = 4,
    parameter int WIN_SCORE     = 11,
    parameter int SERVE_FRAMES  = 60
) (
    input logic               clk_0,
    input logic               rst,
    pong_game_engine_if.slave bus
);
    typedef enum logic [1:0] {
        ST_STARTUP, ST_SERVE, ST_PLAY, ST_OVER
    } state_t;

    localparam int CW = $clog2(SERVE_FRAMES);
    localparam logic [10:0] L_H   = 11'(H_VIDEO);
    localparam logic [10:0] L_V   = 11'(V_VIDEO);
    localparam logic [10:0] L_SW  = 11'(SQUARE_WIDTH);
    localparam logic [10:0] L_PW  = 11'(PADDLE_WIDTH);
    localparam logic [10:0] L_PH  = 11'(PADDLE_HEIGHT);
    localparam logic [10:0] L_P1X = 11'(PADDLE1_X);
    localparam logic [10:0] L_P2X = 11'(PADDLE2_X);
    localparam logic [10:0] L_BS  = 11'(BALL_SPEED);
    localparam logic [9:0]  L_XC  = 10'((H_VIDEO - SQUARE_WIDTH) / 2);
    localparam logic [9:0]  L_YC  = 10'((V_VIDEO - SQUARE_WIDTH) / 2);
    localparam logic [9:0]  L_YB  = 10'(V_VIDEO - SQUARE_WIDTH);
    localparam logic [9:0]  L_X1  = 10'(PADDLE1_X + PADDLE_WIDTH + 1);
    localparam logic [9:0]  L_X2  = 10'(PADDLE2_X - SQUARE_WIDTH - 1);
    localparam logic [3:0]  L_WIN = 4'(WIN_SCORE);
    localparam logic [CW-1:0] L_SL = CW'(SERVE_FRAMES - 1);

    state_t        r_state, w_state;
    logic [9:0]    r_x, r_y, w_x, w_y;
    logic          r_dx, r_dy, w_dx, w_dy;   // 1 = right / down
    logic [CW-1:0] r_cnt, w_cnt;
    logic [3:0]    r_s1, r_s2, w_s1, w_s2;
    logic          r_shown, r_start, r_over;
    logic          w_shown, w_start, w_over;

    logic [10:0] w_spd;
    logic [10:0] w_xe, w_ye, w_p1, w_p2;
    logic [10:0] w_xr, w_xl, w_yd, w_yu;
    logic        w_ov1, w_ov2, w_missl, w_missr, w_hit1, w_hit2;
    logic [3:0]  w_s1i, w_s2i;

`ifdef PONG_SPEEDUP_EN
    logic [1:0] r_hits;
    logic [3:0] r_spd;
    logic       w_serve, w_hit;

    // Any entry into SERVE restarts at base speed; in PLAY the
    // x direction only flips on a paddle hit.
    assign w_serve = (w_state == ST_SERVE) && (r_state != ST_SERVE);
    assign w_hit   = (r_state == ST_PLAY) && (w_dx != r_dx);

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            r_hits <= '0;
            r_spd  <= 4'(BALL_SPEED);
        end else if (w_serve) begin
            r_hits <= '0;
            r_spd  <= 4'(BALL_SPEED);
        end else if (w_hit) begin
            r_hits <= r_hits + 2'd1;
            if (r_hits == 2'd3 && r_spd < 4'd8)
                r_spd <= r_spd + 4'd1;
        end
    end

    assign w_spd = {7'd0, r_spd};
`else
    assign w_spd = L_BS;
`endif

    assign w_xe = {1'b0, r_x};
    assign w_ye = {1'b0, r_y};
    assign w_p1 = {1'b0, bus.paddle1_ypos};
    assign w_p2 = {1'b0, bus.paddle2_ypos};
    assign w_xr = w_xe + w_spd;
    assign w_xl = w_xe - w_spd;
    assign w_yd = w_ye + L_BS;
    assign w_yu = w_ye - L_BS;

    assign w_ov1 = (w_ye + L_SW >= w_p1) && (w_ye <= w_p1 + L_PH);
    assign w_ov2 = (w_ye + L_SW >= w_p2) && (w_ye <= w_p2 + L_PH);

    assign w_missl = !r_dx && (w_xe <= w_spd);
    assign w_missr = r_dx && (w_xe + L_SW + w_spd >= L_H - 11'd1);
    assign w_hit1  = !r_dx && (w_xe >= L_P1X)
                   && (w_xe <= L_P1X + L_PW + w_spd) && w_ov1;
    assign w_hit2  = r_dx && (w_xe + L_SW >= L_P2X - w_spd)
                   && (w_xe <= L_P2X + L_PW) && w_ov2;

    assign w_s1i = (r_s1 >= L_WIN) ? r_s1 : r_s1 + 4'd1;
    assign w_s2i = (r_s2 >= L_WIN) ? r_s2 : r_s2 + 4'd1;

    always_comb begin
        w_state = r_state;
        w_x     = r_x;
        w_y     = r_y;
        w_dx    = r_dx;
        w_dy    = r_dy;
        w_cnt   = r_cnt;
        w_s1    = r_s1;
        w_s2    = r_s2;
        w_shown = r_shown;
        w_start = r_start;
        w_over  = r_over;
        case (r_state)
            ST_STARTUP: if (bus.key_press) begin
                w_state = ST_SERVE;
                w_s1    = '0;
                w_s2    = '0;
                w_x     = L_XC;
                w_y     = L_YC;
                w_dx    = 1'b1;
                w_cnt   = '0;
                w_shown = 1'b1;
                w_start = 1'b0;
            end
            ST_SERVE: if (bus.frame_tick) begin
                w_shown = 1'b1;
                if (r_cnt == L_SL) begin
                    w_state = ST_PLAY;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_PLAY: if (bus.frame_tick) begin
                if (!r_dy && w_ye <= L_BS) begin
                    w_y  = '0;
                    w_dy = 1'b1;
                end else if (r_dy && w_ye + L_SW + L_BS >= L_V) begin
                    w_y  = L_YB;
                    w_dy = 1'b0;
                end else begin
                    w_y = r_dy ? w_yd[9:0] : w_yu[9:0];
                end
                if (w_missl || w_missr) begin
                    // Serve goes back toward the player who missed.
                    w_x     = L_XC;
                    w_y     = L_YC;
                    w_cnt   = '0;
                    w_shown = 1'b0;
                    if (w_missl) w_s2 = w_s2i;
                    else         w_s1 = w_s1i;
                    if ((w_missl ? w_s2i : w_s1i) == L_WIN) begin
                        w_state = ST_OVER;
                        w_over  = 1'b1;
                    end else begin
                        w_state = ST_SERVE;
                    end
                end else if (w_hit1) begin
                    w_x  = L_X1;
                    w_dx = 1'b1;
                end else if (w_hit2) begin
                    w_x  = L_X2;
                    w_dx = 1'b0;
                end else begin
                    w_x = r_dx ? w_xr[9:0] : w_xl[9:0];
                end
            end
            ST_OVER: if (bus.key_press) begin
                w_state = ST_STARTUP;
                w_over  = 1'b0;
                w_start = 1'b1;
            end
            default: w_state = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            r_state <= ST_STARTUP;
            r_x     <= L_XC;
            r_y     <= L_YC;
            r_dx    <= 1'b1;
            r_dy    <= 1'b1;
            r_cnt   <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_shown <= 1'b0;
            r_start <= 1'b1;
            r_over  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_x     <= w_x;
            r_y     <= w_y;
            r_dx    <= w_dx;
            r_dy    <= w_dy;
            r_cnt   <= w_cnt;
            r_s1    <= w_s1;
            r_s2    <= w_s2;
            r_shown <= w_shown;
            r_start <= w_start;
            r_over  <= w_over;
        end
    end

    assign bus.square_xpos  = r_x;
    assign bus.square_ypos  = r_y;
    assign bus.sq_shown     = r_shown;
    assign bus.score_p1     = r_s1;
    assign bus.score_p2     = r_s2;
    assign bus.game_startup = r_start;
    assign bus.game_over    = r_over;
endmodule

// File: tb/tb_pong_game_engine.sv
// Testbench for pong_game_engine: random and scripted play checked
// against a behavioural game model.
module tb_pong_game_engine;
    logic clk_0 = 1'b0;
    logic rst;
    pong_game_engine_if bus_if();

    pong_game_engine dut (
        .clk_0(clk_0),
        .rst  (rst),
        .bus  (bus_if)
    );

    always #5 clk_0 = ~clk_0;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 startup, 1 serve, 2 play, 3 game over
    int m_st, m_x, m_y, m_dir, m_vy, m_spd, m_hits;
    int m_s1, m_s2, m_cnt;
    bit m_shown, m_start, m_over;

    localparam logic [30:0] RST_VEC =
        {10'd312, 10'd232, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0};

    function automatic logic [30:0] dut_vec();
        return {bus_if.square_xpos, bus_if.square_ypos, bus_if.sq_shown,
                bus_if.score_p1, bus_if.score_p2,
                bus_if.game_startup, bus_if.game_over};
    endfunction

    function automatic logic [30:0] mdl_vec();
        return {10'(m_x), 10'(m_y), m_shown, 4'(m_s1), 4'(m_s2),
                m_start, m_over};
    endfunction

    function automatic int track(int y);
        return (y >= 40) ? y - 40 : 0;
    endfunction

    function automatic int anti(int y);
        return (y >= 240) ? 0 : 380;
    endfunction

    task automatic model_reset();
        m_st = 0; m_x = 312; m_y = 232; m_dir = 1; m_vy = 4;
        m_spd = 4; m_hits = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0;
        m_shown = 0; m_start = 1; m_over = 0;
    endtask

    task automatic model_step(bit key, bit tick, int p1, int p2);
        int ox, oy;
        bit hit;
        ox = m_x; oy = m_y; hit = 0;
        case (m_st)
            0: if (key) begin
                m_st = 1; m_s1 = 0; m_s2 = 0; m_x = 312; m_y = 232;
                m_dir = 1; m_cnt = 0; m_shown = 1; m_start = 0;
                m_spd = 4; m_hits = 0;
            end
            1: if (tick) begin
                m_shown = 1;
                if (m_cnt == 59) begin m_st = 2; m_cnt = 0; end
                else m_cnt++;
            end
            2: if (tick) begin
                if (m_vy < 0 && oy <= 4) begin m_y = 0; m_vy = 4; end
                else if (m_vy > 0 && oy + 20 >= 480) begin
                    m_y = 464; m_vy = -4;
                end else m_y = oy + m_vy;
                if ((m_dir < 0 && ox <= m_spd) ||
                    (m_dir > 0 && ox + 16 + m_spd >= 639)) begin
                    if (m_dir < 0) m_s2 = (m_s2 < 11) ? m_s2 + 1 : m_s2;
                    else           m_s1 = (m_s1 < 11) ? m_s1 + 1 : m_s1;
                    m_x = 312; m_y = 232; m_cnt = 0; m_shown = 0;
                    m_spd = 4; m_hits = 0;
                    if ((m_dir < 0 ? m_s2 : m_s1) == 11) begin
                        m_st = 3; m_over = 1;
                    end else m_st = 1;
                end else if (m_dir < 0 && ox >= 20 && ox <= 32 + m_spd &&
                             oy + 16 >= p1 && oy <= p1 + 96) begin
                    m_x = 33; m_dir = 1; hit = 1;
                end else if (m_dir > 0 && ox + 16 >= 608 - m_spd &&
                             ox <= 620 && oy + 16 >= p2 && oy <= p2 + 96) begin
                    m_x = 591; m_dir = -1; hit = 1;
                end else begin
                    m_x = ox + m_dir * m_spd;
                end
                if (hit) begin
                    m_hits = (m_hits + 1) % 4;
`ifdef PONG_SPEEDUP_EN
                    if (m_hits == 0 && m_spd < 8) m_spd++;
`endif
                end
            end
            3: if (key) begin m_st = 0; m_over = 0; m_start = 1; end
            default: ;
        endcase
    endtask

    task automatic cyc(bit key, bit tick, int p1, int p2);
        bus_if.key_press    = key;
        bus_if.frame_tick   = tick;
        bus_if.paddle1_ypos = 10'(p1);
        bus_if.paddle2_ypos = 10'(p2);
        @(posedge clk_0);
        model_step(key, tick, p1, p2);
        #1;
        bus_if.key_press  = 1'b0;
        bus_if.frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.key_press = 1'b0;
        bus_if.frame_tick = 1'b0;
        bus_if.paddle1_ypos = '0;
        bus_if.paddle2_ypos = '0;
        @(posedge clk_0);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", dut_vec(), RST_VEC);
        end
    endtask

    task automatic test_serve();
        logic [30:0] exp;
        cyc(1, 0, 0, 0);
        exp = {10'd312, 10'd232, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0};
        n_checks++;
        if (dut_vec() !== exp) begin
            n_fail++;
            $display("FAIL serve_start: got %h want %h", dut_vec(), exp);
        end
        for (int i = 0; i < 60; i++) begin
            cyc(0, 1, 0, 0);
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL serve_hold: got %h want %h", dut_vec(), mdl_vec());
            end
        end
        cyc(0, 1, 0, 0);
        n_checks++;
        if ({bus_if.square_xpos, bus_if.square_ypos} !== {10'd316, 10'd236}) begin
            n_fail++;
            $display("FAIL serve_first_move: got %0d,%0d want 316,236",
                     bus_if.square_xpos, bus_if.square_ypos);
        end
    endtask

    task automatic test_wall_paddle();
        bit s591, s33, s0, s464, after0, after33;
        s591 = 0; s33 = 0; s0 = 0; s464 = 0; after0 = 0; after33 = 0;
        for (int i = 0; i < 600; i++) begin
            cyc(0, 1, track(m_y), track(m_y));
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL rally: got %h want %h", dut_vec(), mdl_vec());
            end
            if (after0) begin
                after0 = 0;
                n_checks++;
                if (bus_if.square_ypos !== 10'd4) begin
                    n_fail++;
                    $display("FAIL top_bounce_next: got %0d want 4", bus_if.square_ypos);
                end
            end
            if (after33) begin
                after33 = 0;
                n_checks++;
                if (bus_if.square_xpos !== 10'd37) begin
                    n_fail++;
                    $display("FAIL p1_hit_next: got %0d want 37", bus_if.square_xpos);
                end
            end
            if (m_y == 0 && !s0) after0 = 1;
            if (m_x == 33 && !s33) after33 = 1;
            if (bus_if.square_xpos == 10'd591) s591 = 1;
            if (bus_if.square_xpos == 10'd33)  s33 = 1;
            if (bus_if.square_ypos == 10'd0)   s0 = 1;
            if (bus_if.square_ypos == 10'd464) s464 = 1;
        end
        n_checks++;
        if ({s591, s33, s0, s464} !== 4'b1111) begin
            n_fail++;
            $display("FAIL bounce_seen: got %b want 1111", {s591, s33, s0, s464});
        end
    endtask

    task automatic test_key_tick_same();
        do_reset();
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 60; i++) cyc(0, 1, 0, 0);
        n_checks++;
        if ({bus_if.square_xpos, bus_if.sq_shown} !== {10'd312, 1'b1}) begin
            n_fail++;
            $display("FAIL key_tick_hold: got %0d want 312", bus_if.square_xpos);
        end
        cyc(0, 1, 0, 0);
        n_checks++;
        if (bus_if.square_xpos !== 10'd316) begin
            n_fail++;
            $display("FAIL key_tick_move: got %0d want 316", bus_if.square_xpos);
        end
    endtask

    task automatic test_left_miss();
        int n;
        logic [30:0] exp;
        do_reset();
        cyc(1, 0, 0, 0);
        n = 0;
        while (m_s2 == 0 && n < 2000) begin
            cyc(0, 1, anti(m_y), track(m_y));
            n++;
        end
        exp = {10'd312, 10'd232, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0};
        n_checks++;
        if (dut_vec() !== exp) begin
            n_fail++;
            $display("FAIL left_miss: got %h want %h", dut_vec(), exp);
        end
        for (int i = 0; i < 61; i++) cyc(0, 1, anti(m_y), track(m_y));
        n_checks++;
        if ({bus_if.square_xpos, bus_if.sq_shown} !== {10'd308, 1'b1}) begin
            n_fail++;
            $display("FAIL serve_to_loser: got %0d want 308", bus_if.square_xpos);
        end
        n = 0;
        while (m_s2 == 1 && n < 2000) begin
            cyc(0, 1, anti(m_y), track(m_y));
            n++;
        end
        n_checks++;
        if (bus_if.score_p2 !== 4'd2 || bus_if.score_p1 !== 4'd0) begin
            n_fail++;
            $display("FAIL second_left_miss: got %0d:%0d want 0:2",
                     bus_if.score_p1, bus_if.score_p2);
        end
    endtask

    task automatic test_game_over();
        int n, pol, tot;
        logic [30:0] exp;
        pol = 0; tot = -1; n = 0;
        while (m_st != 3 && n < 30000) begin
            if (m_s1 + m_s2 != tot) begin
                tot = m_s1 + m_s2;
                pol = int'($urandom_range(0, 2));
            end
            case (pol)
                0: cyc(0, 1, anti(m_y), anti(m_y));
                1: cyc(0, 1, anti(m_y), track(m_y));
                default: cyc(0, 1, track(m_y), anti(m_y));
            endcase
            n++;
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL game_play: got %h want %h", dut_vec(), mdl_vec());
            end
        end
        n_checks++;
        if (m_st != 3 || bus_if.game_over !== 1'b1 || bus_if.sq_shown !== 1'b0 ||
            (bus_if.score_p1 !== 4'd11 && bus_if.score_p2 !== 4'd11)) begin
            n_fail++;
            $display("FAIL game_over: got over=%b s=%0d:%0d want over=1 and an 11",
                     bus_if.game_over, bus_if.score_p1, bus_if.score_p2);
        end
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        n_checks++;
        if (dut_vec() !== mdl_vec() || bus_if.game_startup !== 1'b1 ||
            bus_if.game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL over_to_startup: got %h want %h", dut_vec(), mdl_vec());
        end
        cyc(1, 0, 0, 0);
        exp = {10'd312, 10'd232, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0};
        n_checks++;
        if (dut_vec() !== exp) begin
            n_fail++;
            $display("FAIL restart_clear: got %h want %h", dut_vec(), exp);
        end
    endtask

    task automatic test_rst_mid_play();
        for (int i = 0; i < 80; i++) cyc(0, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", dut_vec(), RST_VEC);
        end
        @(posedge clk_0);
        #1;
        model_reset();
        rst = 1'b0;
        cyc(0, 1, 0, 0);
        n_checks++;
        if (dut_vec() !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_tick_ignored: got %h want %h", dut_vec(), RST_VEC);
        end
    endtask

    task automatic test_random();
        bit k, t;
        for (int i = 0; i < 4000; i++) begin
            k = ($urandom_range(0, 19) == 0);
            t = ($urandom_range(0, 1) == 0);
            cyc(k, t, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL random: got %h want %h", dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        test_reset();
        test_serve();
        test_wall_paddle();
        test_key_tick_same();
        test_left_miss();
        test_game_over();
        test_rst_mid_play();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
